// File: rtl/fdivsqrt_arb_pkg.sv
// Shared types for the divide/sqrt datapath arbiter.
// Imported by the arbiter top and its round-robin helper.
package fdivsqrt_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RUN,
    ARB_HOLD
  } arbstate_t;

  localparam int ARB_TAGW_DEFAULT = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a last-grant flop.
// Requester A wins ties when B was granted last.
module rr_arb2
  import fdivsqrt_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic reqA,
  input  logic reqB,
  output logic gntA,
  output logic gntB
);

  logic lastA;

  assign gntA = reqA & (~reqB | ~lastA);
  assign gntB = reqB & (~reqA | lastA);

  // Reset to A so B takes the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      lastA <= 1'b1;
    else if (en && (gntA || gntB))
      lastA <= gntA;
  end

endmodule

// File: rtl/fdivsqrt_arb.sv
// Shares the div/sqrt datapath between integer and FP requesters,
// tracks the in-flight tag and returns it through a response handshake.
module fdivsqrt_arb
  import fdivsqrt_arb_pkg::*;
#(
  parameter int TAGW   = ARB_TAGW_DEFAULT,
  parameter int MAXCYC = 64,
  localparam int CNTW  = $clog2(MAXCYC+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IReqValid,
  input  logic [TAGW-1:0] IReqTag,
  output logic            IReqReady,
  input  logic            FReqValid,
  input  logic [TAGW-1:0] FReqTag,
  output logic            FReqReady,
  input  logic            Flush,
  input  logic            DivBusy,
  input  logic            DivDone,
  output logic            IDivStart,
  output logic            FDivStart,
  output logic            HoldStall,
  output logic            RspValid,
  output logic            RspIsInt,
  output logic [TAGW-1:0] RspTag,
  input  logic            RspReady,
  output logic            Timeout
);

  arbstate_t       state;
  logic [CNTW-1:0] cnt;
  logic [TAGW-1:0] tagQ;
  logic            isIntQ;

  logic live;
  logic issue;
  logic gntI;
  logic gntF;
  logic done;

  assign live  = ~reset & ~Flush;
  assign issue = live & ~DivBusy
               & (state == ARB_IDLE);

  rr_arb2 uRr (
    .clk   (clk),
    .reset (reset),
    .en    (issue),
    .reqA  (IReqValid),
    .reqB  (FReqValid),
    .gntA  (gntI),
    .gntB  (gntF)
  );

  assign IReqReady = issue & gntI;
  assign FReqReady = issue & gntF;
  assign IDivStart = IReqReady;
  assign FDivStart = FReqReady;

  assign done = live & DivDone
              & (state == ARB_RUN);

  assign HoldStall = live & (state == ARB_HOLD);
  assign RspValid  = done | HoldStall;
  assign RspIsInt  = RspValid & isIntQ;
  assign RspTag    = RspValid ? tagQ : '0;

  assign Timeout = live & ~DivDone
                 & (state == ARB_RUN)
                 & (cnt == CNTW'(MAXCYC-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      cnt    <= '0;
      tagQ   <= '0;
      isIntQ <= 1'b0;
    end else if (Flush) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (IReqReady || FReqReady) begin
            state  <= ARB_RUN;
            tagQ   <= gntI ? IReqTag : FReqTag;
            isIntQ <= gntI;
          end
        end
        ARB_RUN: begin
          cnt <= cnt + CNTW'(1);
          if (DivDone)
            state <= RspReady ? ARB_IDLE : ARB_HOLD;
          else if (Timeout)
            state <= ARB_IDLE;
        end
        ARB_HOLD: begin
          if (RspReady)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdivsqrt_arb.sv
// Self-checking bench for fdivsqrt_arb: directed vector table,
// hand-written corner sequences, then random stimulus vs a reference model.
module tb_fdivsqrt_arb;

  localparam int TAGW   = 5;
  localparam int MAXCYC = 8;

  typedef struct packed {
    logic            rst;
    logic            iv;
    logic [TAGW-1:0] it;
    logic            fv;
    logic [TAGW-1:0] ft;
    logic            fl;
    logic            busy;
    logic            done;
    logic            rdy;
  } in_t;

  typedef struct packed {
    logic            ir;
    logic            fr;
    logic            is;
    logic            fs;
    logic            rv;
    logic            ri;
    logic            hs;
    logic            to;
    logic [TAGW-1:0] rt;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            IReqValid;
  logic [TAGW-1:0] IReqTag;
  logic            IReqReady;
  logic            FReqValid;
  logic [TAGW-1:0] FReqTag;
  logic            FReqReady;
  logic            Flush;
  logic            DivBusy;
  logic            DivDone;
  logic            IDivStart;
  logic            FDivStart;
  logic            HoldStall;
  logic            RspValid;
  logic            RspIsInt;
  logic [TAGW-1:0] RspTag;
  logic            RspReady;
  logic            Timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fdivsqrt_arb #(.TAGW(TAGW), .MAXCYC(MAXCYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .IReqValid (IReqValid),
    .IReqTag   (IReqTag),
    .IReqReady (IReqReady),
    .FReqValid (FReqValid),
    .FReqTag   (FReqTag),
    .FReqReady (FReqReady),
    .Flush     (Flush),
    .DivBusy   (DivBusy),
    .DivDone   (DivDone),
    .IDivStart (IDivStart),
    .FDivStart (FDivStart),
    .HoldStall (HoldStall),
    .RspValid  (RspValid),
    .RspIsInt  (RspIsInt),
    .RspTag    (RspTag),
    .RspReady  (RspReady),
    .Timeout   (Timeout)
  );

  function automatic in_t ii(
    logic rst, logic iv, logic [TAGW-1:0] it,
    logic fv, logic [TAGW-1:0] ft, logic fl,
    logic busy, logic done, logic rdy);
    in_t x;
    x.rst = rst; x.iv = iv; x.it = it;
    x.fv = fv; x.ft = ft; x.fl = fl;
    x.busy = busy; x.done = done; x.rdy = rdy;
    return x;
  endfunction

  function automatic out_t oo(
    logic ir, logic fr, logic is, logic fs,
    logic rv, logic ri, logic hs, logic to,
    logic [TAGW-1:0] rt);
    out_t e;
    e.ir = ir; e.fr = fr; e.is = is; e.fs = fs;
    e.rv = rv; e.ri = ri; e.hs = hs; e.to = to;
    e.rt = rt;
    return e;
  endfunction

  // Drive one cycle, compare outputs at the falling edge.
  task automatic cycle(input in_t x, input out_t e, input string nm);
    out_t got;
    reset     = x.rst;
    IReqValid = x.iv;
    IReqTag   = x.it;
    FReqValid = x.fv;
    FReqTag   = x.ft;
    Flush     = x.fl;
    DivBusy   = x.busy;
    DivDone   = x.done;
    RspReady  = x.rdy;
    @(negedge clk);
    got = {IReqReady, FReqReady, IDivStart, FDivStart,
           RspValid, RspIsInt, HoldStall, Timeout, RspTag};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got ir%b fr%b is%b fs%b rv%b ri%b hs%b to%b tag%0d, expected ir%b fr%b is%b fs%b rv%b ri%b hs%b to%b tag%0d",
        nm, got.ir, got.fr, got.is, got.fs, got.rv, got.ri, got.hs,
        got.to, got.rt, e.ir, e.fr, e.is, e.fs, e.rv, e.ri, e.hs,
        e.to, e.rt);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: one in-flight op, age counts cycles since start.
  int              mPhase;
  int              mAge;
  bit              mLastInt;
  logic [TAGW-1:0] mTag;
  bit              mInt;

  task automatic model(input in_t x, output out_t e);
    bit pickInt;
    e = '0;
    if (x.rst) begin
      mPhase = 0; mAge = 0; mLastInt = 1; mTag = 0; mInt = 0;
    end else if (x.fl) begin
      mPhase = 0; mAge = 0;
    end else if (mPhase == 0) begin
      if (!x.busy && (x.iv || x.fv)) begin
        pickInt = (x.iv && x.fv) ? !mLastInt : x.iv;
        e.ir = pickInt; e.is = pickInt;
        e.fr = !pickInt; e.fs = !pickInt;
        mLastInt = pickInt;
        mInt = pickInt;
        mTag = pickInt ? x.it : x.ft;
        mPhase = 1; mAge = 0;
      end
    end else if (mPhase == 1) begin
      mAge++;
      if (x.done) begin
        e.rv = 1; e.ri = mInt; e.rt = mTag;
        mPhase = x.rdy ? 0 : 2;
      end else if (mAge == MAXCYC) begin
        e.to = 1;
        mPhase = 0;
      end
    end else begin
      e.rv = 1; e.ri = mInt; e.rt = mTag; e.hs = 1;
      if (x.rdy) mPhase = 0;
    end
  endtask

  vec_t tbl[$];
  out_t z;

  initial begin
    in_t  x;
    out_t e;
    logic iv, fv;
    logic [TAGW-1:0] it, ft;

    z = '0;

    // reset, ties alternate, FP-only op
    tbl.push_back('{ii(1,1,7,1,9,0,0,1,1), z});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,0), z});
    tbl.push_back('{ii(0,1,7,1,9,0,0,0,0), oo(0,1,0,1,0,0,0,0,0)});
    tbl.push_back('{ii(0,1,7,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,9)});
    tbl.push_back('{ii(0,1,7,1,9,0,0,0,0), oo(1,0,1,0,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,1,9,0,0,1,1), oo(0,0,0,0,1,1,0,0,7)});
    tbl.push_back('{ii(0,1,7,1,9,0,0,0,0), oo(0,1,0,1,0,0,0,0,0)});
    tbl.push_back('{ii(0,1,7,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,9)});
    tbl.push_back('{ii(0,1,7,1,9,0,0,0,0), oo(1,0,1,0,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,1,1), oo(0,0,0,0,1,1,0,0,7)});
    tbl.push_back('{ii(0,0,0,1,3,0,0,0,0), oo(0,1,0,1,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,3)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,0), z});
    // backpressured response
    tbl.push_back('{ii(0,1,5,0,0,0,0,0,0), oo(1,0,1,0,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,1,0), oo(0,0,0,0,1,1,0,0,5)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,0), oo(0,0,0,0,1,1,1,0,5)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,0), oo(0,0,0,0,1,1,1,0,5)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,1), oo(0,0,0,0,1,1,1,0,5)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,0,0), z});
    tbl.push_back('{ii(0,0,0,0,0,0,0,1,1), z});
    // flush in RUN, stale datapath blocks issue
    tbl.push_back('{ii(0,0,0,1,2,0,0,0,0), oo(0,1,0,1,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,1,4,1,1,0,1), z});
    tbl.push_back('{ii(0,0,0,1,4,0,1,0,1), z});
    tbl.push_back('{ii(0,0,0,1,4,0,1,1,1), z});
    tbl.push_back('{ii(0,0,0,1,4,0,0,0,0), oo(0,1,0,1,0,0,0,0,0)});
    tbl.push_back('{ii(0,0,0,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,4)});

    for (int k = 0; k < tbl.size(); k++)
      cycle(tbl[k].i, tbl[k].o, $sformatf("vec[%0d]", k));

    // watchdog: timeout pulse 8 cycles after start
    cycle(ii(0,1,1,0,0,0,1'b0,0,0), oo(1,0,1,0,0,0,0,0,0), "to_start");
    for (int k = 1; k < MAXCYC; k++)
      cycle(ii(0,0,0,0,0,0,1,0,0), z, $sformatf("to_wait%0d", k));
    cycle(ii(0,0,0,0,0,0,1,0,0), oo(0,0,0,0,0,0,0,1,0), "to_pulse");
    cycle(ii(0,0,0,0,0,0,0,1,1), z, "to_stray");
    cycle(ii(0,1,8,1,9,0,0,0,0), oo(0,1,0,1,0,0,0,0,0), "to_next");
    cycle(ii(0,0,0,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,9), "to_rsp");

    // reset while holding a response
    cycle(ii(0,0,0,1,6,0,0,0,0), oo(0,1,0,1,0,0,0,0,0), "rh_start");
    cycle(ii(0,0,0,0,0,0,0,1,0), oo(0,0,0,0,1,0,0,0,6), "rh_done");
    cycle(ii(1,0,0,0,0,0,0,0,0), z, "rh_reset");
    cycle(ii(0,1,7,1,9,0,0,0,0), oo(0,1,0,1,0,0,0,0,0), "rh_tie");
    cycle(ii(0,0,0,0,0,0,0,1,1), oo(0,0,0,0,1,0,0,0,9), "rh_rsp");

    // random traffic against the model
    iv = 0; fv = 0; it = 0; ft = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!iv) begin
        iv = ($urandom % 3) == 0;
        it = TAGW'($urandom);
      end
      if (!fv) begin
        fv = ($urandom % 3) == 0;
        ft = TAGW'($urandom);
      end
      x = ii(n == 0 || ($urandom % 300) == 0,
             iv, it, fv, ft,
             ($urandom % 40) == 0,
             ($urandom % 4) == 0,
             ($urandom % 6) == 0,
             ($urandom % 10) < 6);
      model(x, e);
      cycle(x, e, "rand");
      if (e.ir) iv = 0;
      if (e.fr) fv = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_arb.md
Name: fdivsqrt_arb

Overview:
Controller that shares the single combined divide/square-root datapath between the integer divider requester and the FP div/sqrt requester. It arbitrates with a two-way round-robin scheme and issues one-cycle start pulses to the datapath. It tracks the in-flight operation's tag and type and presents the completion through a valid/ready response handshake. If the response is not accepted, it holds the datapath's M-stage outputs. It sits beside the fdivsqrt datapath in the FPU and replaces direct start wiring from the execute stage.

Parameters:
TAGW, 5, width of destination-register tag carried with each request
MAXCYC, 64, watchdog limit in cycles for one operation in RUN
CNTW, $clog2(MAXCYC+1), watchdog counter width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
IReqValid  in  1  integer div/rem request valid
IReqTag  in  TAGW  integer request tag
IReqReady  out  1  integer request accepted this cycle
FReqValid  in  1  FP div/sqrt request valid
FReqTag  in  TAGW  FP request tag
FReqReady  out  1  FP request accepted this cycle
Flush  in  1  kill in-flight operation and pending handshakes
DivBusy  in  1  datapath busy (FDivBusyE)
DivDone  in  1  datapath completion pulse (FDivDoneE)
IDivStart  out  1  one-cycle start to datapath, integer operation
FDivStart  out  1  one-cycle start to datapath, FP operation
HoldStall  out  1  stall M stage so datapath result registers hold
RspValid  out  1  result available
RspIsInt  out  1  result belongs to integer requester
RspTag  out  TAGW  tag of completing operation
RspReady  in  1  consumer accepts result
Timeout  out  1  one-cycle pulse: watchdog expired, operation abandoned

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset state: IDLE, watchdog count 0, LastGrantInt=1 (FP wins the first tie), captured tag 0, IsInt 0. All outputs are 0 during and immediately after reset.
- States:
  - IDLE: no operation in flight.
  - RUN: operation issued, waiting for DivDone.
  - HOLD: done, response not yet accepted.
- IDLE, Flush=0, DivBusy=0:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one not granted last.
  - Ready and Start for the granted side are asserted combinationally in the same cycle. Tag, IsInt and LastGrantInt are registered. Next state is RUN.
- IDLE with DivBusy=1: no grant. This protects against a stale datapath after a flush.
- RUN:
  - Watchdog count increments every cycle.
  - DivDone=1: RspValid=1 in the same cycle. If RspReady=1, go to IDLE; otherwise go to HOLD.
  - Count reaching MAXCYC with no DivDone: Timeout pulses, go to IDLE, no response.
- HOLD: RspValid=1 and HoldStall=1. RspReady=1 goes to IDLE.
- RspTag and RspIsInt come from the registers whenever RspValid=1. They are 0 otherwise.
- Flush has priority in every state:
  - It forces Ready, Start and RspValid low that cycle.
  - Next state is IDLE and the watchdog count clears. LastGrantInt is unchanged.
- DivDone in IDLE (stray or post-flush) is ignored: no RspValid.
- Only IDLE accepts requests, so the minimum issue interval is 2 cycles, and responses return in issue order (at most one outstanding).
- Requesters must hold Valid and Tag stable until Ready; the arbiter does not buffer requests.
- Reset mid-operation behaves like Flush and additionally sets LastGrantInt=1.

Decomposition:
- Shared package fdivsqrt_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_RUN, ARB_HOLD} arbstate_t
  - localparam ARB_TAGW_DEFAULT
- One sub-module, rr_arb2: a two-input round-robin grant with a last-grant flop, enable and synchronous reset. It is reused by other shared FPU resources.

Test Plan:
- Only FReqValid=1 with tag 3 in IDLE → FReqReady=1 and FDivStart=1 in the same cycle. After DivDone with RspReady=1: RspValid=1, RspTag=3, RspIsInt=0, then back to IDLE.
- IReqValid and FReqValid both high after reset → FP granted first. On the next tie, integer is granted. This alternation holds over 4 operations.
- DivDone with RspReady=0 for 3 cycles → HOLD, with HoldStall=1 and RspValid=1 for 4 cycles total. The response completes when RspReady=1.
- Flush while in RUN, then DivDone 2 cycles later → no RspValid, state IDLE. New request accepted only once DivBusy=0.
- MAXCYC=8 and DivDone never asserted → Timeout pulses exactly 8 cycles after Start, state returns to IDLE, no response.
- Reset asserted in HOLD → next cycle all outputs 0 and state IDLE. A tie afterwards grants FP.
